// File: rtl/reg_transfer_ctrl.sv
// Register file sequencer: transfer, inc/dec and stack push/pull opcodes.
// Drives write strobes, data buses and the stack memory handshake.
module reg_transfer_ctrl #(
    parameter logic [7:0] STACK_PAGE = 8'h01,
    parameter logic [7:0] PUSH_BMASK = 8'h30
) (
    input  logic        clk_1,
    input  logic        rst,
    input  logic        op_valid,
    output logic        op_ready,
    input  logic [7:0]  opcode,
    input  logic [7:0]  acc_q,
    input  logic [7:0]  x_q,
    input  logic [7:0]  y_q,
    input  logic [7:0]  sp_q,
    input  logic [7:0]  status_q,
    output logic        accumulator_con,
    output logic        x_con,
    output logic        y_con,
    output logic        stack_pointer_con,
    output logic        status_con,
    output logic [7:0]  data_in,
    output logic [7:0]  data_status,
    output logic        mem_req,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_wdata,
    input  logic        mem_ack,
    input  logic [7:0]  mem_rdata,
    output logic        done,
    output logic        illegal
);

    typedef enum logic [2:0] {
        IDLE, XFER, PUSH, SP_DEC, SP_INC, PULL, WB, BAD
    } state_t;

    typedef enum logic [1:0] {T_A, T_X, T_Y, T_SP} tgt_t;

    localparam logic [7:0] OP_PHA = 8'h48;
    localparam logic [7:0] OP_PHP = 8'h08;
    localparam logic [7:0] OP_PLA = 8'h68;
    localparam logic [7:0] OP_PLP = 8'h28;

    state_t     state;
    state_t     entry;
    logic [7:0] op_r;
    logic [7:0] pull_d;
    logic [7:0] xres;
    tgt_t       tgt;

    // N lands in bit 7, Z in bit 1; other flags pass through
    function automatic logic [7:0] nz(input logic [7:0] p, input logic [7:0] r);
        return {r[7], p[6:2], r == 8'h00, p[0]};
    endfunction

    always_comb begin
        entry = BAD;
        case (opcode)
            8'hAA, 8'hA8, 8'h8A, 8'h98, 8'hBA,
            8'h9A, 8'hE8, 8'hCA, 8'hC8, 8'h88: entry = XFER;
            OP_PHA, OP_PHP:                    entry = PUSH;
            OP_PLA, OP_PLP:                    entry = SP_INC;
            default:                           entry = BAD;
        endcase
    end

    always_comb begin
        tgt  = T_X;
        xres = x_q;
        case (op_r)
            8'hAA: begin tgt = T_X;  xres = acc_q;       end
            8'hA8: begin tgt = T_Y;  xres = acc_q;       end
            8'h8A: begin tgt = T_A;  xres = x_q;         end
            8'h98: begin tgt = T_A;  xres = y_q;         end
            8'hBA: begin tgt = T_X;  xres = sp_q;        end
            8'h9A: begin tgt = T_SP; xres = x_q;         end
            8'hE8: begin tgt = T_X;  xres = x_q + 8'd1;  end
            8'hCA: begin tgt = T_X;  xres = x_q - 8'd1;  end
            8'hC8: begin tgt = T_Y;  xres = y_q + 8'd1;  end
            8'h88: begin tgt = T_Y;  xres = y_q - 8'd1;  end
            default: begin tgt = T_X; xres = x_q;        end
        endcase
    end

    always_ff @(posedge clk_1 or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            op_r   <= 8'h00;
            pull_d <= 8'h00;
        end else begin
            unique case (state)
                IDLE: begin
                    if (op_valid) begin
                        op_r  <= opcode;
                        state <= entry;
                    end
                end
                XFER, SP_DEC, WB, BAD: state <= IDLE;
                PUSH: if (mem_ack) state <= SP_DEC;
                SP_INC: state <= PULL;
                PULL: begin
                    if (mem_ack) begin
                        pull_d <= mem_rdata;
                        state  <= WB;
                    end
                end
            endcase
        end
    end

    always_comb begin
        op_ready          = 1'b0;
        accumulator_con   = 1'b0;
        x_con             = 1'b0;
        y_con             = 1'b0;
        stack_pointer_con = 1'b0;
        status_con        = 1'b0;
        data_in           = 8'h00;
        data_status       = 8'h00;
        mem_req           = 1'b0;
        mem_we            = 1'b0;
        mem_wdata         = 8'h00;
        done              = 1'b0;
        illegal           = 1'b0;
        unique case (state)
            IDLE: op_ready = !rst;
            XFER: begin
                done    = 1'b1;
                data_in = xres;
                unique case (tgt)
                    T_A:  accumulator_con   = 1'b1;
                    T_X:  x_con             = 1'b1;
                    T_Y:  y_con             = 1'b1;
                    T_SP: stack_pointer_con = 1'b1;
                endcase
                if (tgt != T_SP) begin
                    status_con  = 1'b1;
                    data_status = nz(status_q, xres);
                end
            end
            PUSH: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_wdata = (op_r == OP_PHP) ? (status_q | PUSH_BMASK) : acc_q;
            end
            SP_DEC: begin
                stack_pointer_con = 1'b1;
                data_in           = sp_q - 8'd1;
                done              = 1'b1;
            end
            SP_INC: begin
                stack_pointer_con = 1'b1;
                data_in           = sp_q + 8'd1;
            end
            PULL: mem_req = 1'b1;
            WB: begin
                done       = 1'b1;
                status_con = 1'b1;
                if (op_r == OP_PLP) begin
                    data_status = {pull_d[7:6], status_q[5:4], pull_d[3:0]};
                end else begin
                    accumulator_con = 1'b1;
                    data_in         = pull_d;
                    data_status     = nz(status_q, pull_d);
                end
            end
            BAD: illegal = 1'b1;
        endcase
        mem_addr = mem_req ? {STACK_PAGE, sp_q} : 16'h0000;
    end

endmodule

// File: tb/tb_reg_transfer_ctrl.sv
// Scoreboard bench for reg_transfer_ctrl with a small register file model.
// Each step holds the outputs expected in a cycle and the inputs for its edge.
module tb_reg_transfer_ctrl;

    typedef struct packed {
        logic        rdy;
        logic        a;
        logic        x;
        logic        y;
        logic        s;
        logic        st;
        logic [7:0]  din;
        logic [7:0]  dst;
        logic        req;
        logic        we;
        logic [15:0] addr;
        logic [7:0]  wd;
        logic        dn;
        logic        il;
    } obs_t;

    typedef struct {
        logic       v;
        logic [7:0] op;
        logic       ack;
        logic [7:0] rd;
        obs_t       e;
    } step_t;

    logic        clk_1 = 1'b0;
    logic        rst = 1'b1;
    logic        op_valid = 1'b0;
    logic        op_ready;
    logic [7:0]  opcode = 8'h00;
    logic        accumulator_con, x_con, y_con, stack_pointer_con, status_con;
    logic [7:0]  data_in, data_status;
    logic        mem_req, mem_we;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_ack = 1'b0;
    logic [7:0]  mem_rdata = 8'h00;
    logic        done, illegal;

    logic [7:0]  ra, rx, ry, rs, rp;
    logic [7:0]  pa, px, py, ps, pp;
    logic        load_en = 1'b0;

    int          n_chk = 0;
    int          n_fail = 0;
    step_t       sq[$];
    obs_t        act;

    always #5 clk_1 = ~clk_1;

    reg_transfer_ctrl dut (
        .clk_1(clk_1), .rst(rst),
        .op_valid(op_valid), .op_ready(op_ready), .opcode(opcode),
        .acc_q(ra), .x_q(rx), .y_q(ry), .sp_q(rs), .status_q(rp),
        .accumulator_con(accumulator_con), .x_con(x_con), .y_con(y_con),
        .stack_pointer_con(stack_pointer_con), .status_con(status_con),
        .data_in(data_in), .data_status(data_status),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .done(done), .illegal(illegal)
    );

    assign act = {op_ready, accumulator_con, x_con, y_con, stack_pointer_con,
                  status_con, data_in, data_status, mem_req, mem_we,
                  mem_addr, mem_wdata, done, illegal};

    always @(posedge clk_1) begin
        if (load_en) begin
            ra <= pa; rx <= px; ry <= py; rs <= ps; rp <= pp;
        end else begin
            if (accumulator_con)   ra <= data_in;
            if (x_con)             rx <= data_in;
            if (y_con)             ry <= data_in;
            if (stack_pointer_con) rs <= data_in;
            if (status_con)        rp <= data_status;
        end
    end

    function automatic obs_t ob(logic rdy, logic [4:0] sb, logic [7:0] din,
                                logic [7:0] dst, logic req, logic we,
                                logic [15:0] ad, logic [7:0] wd,
                                logic dn, logic il);
        obs_t o;
        o.rdy = rdy;
        {o.a, o.x, o.y, o.s, o.st} = sb;
        o.din = din; o.dst = dst; o.req = req; o.we = we;
        o.addr = ad; o.wd = wd; o.dn = dn; o.il = il;
        return o;
    endfunction

    function automatic obs_t idl();
        return ob(1'b1, 5'b0, 8'h00, 8'h00, 1'b0, 1'b0, 16'h0, 8'h00, 1'b0, 1'b0);
    endfunction

    // buses only matter while something consumes them
    function automatic obs_t msk(obs_t e);
        obs_t m;
        m = '1;
        if (!e.st) m.dst = '0;
        if (!(e.a | e.x | e.y | e.s)) m.din = '0;
        if (!e.req) m.addr = '0;
        if (!(e.req && e.we)) m.wd = '0;
        return m;
    endfunction

    function automatic step_t stp(logic v, logic [7:0] op, logic ack,
                                  logic [7:0] rd, obs_t e);
        step_t s;
        s.v = v; s.op = op; s.ack = ack; s.rd = rd; s.e = e;
        return s;
    endfunction

    task automatic load(input logic [7:0] a, x, y, s, p);
        @(negedge clk_1);
        {pa, px, py, ps, pp} = {a, x, y, s, p};
        load_en = 1'b1;
        @(negedge clk_1);
        load_en = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk_1);
        n_chk++;
        if (act !== obs_t'('0)) begin
            n_fail++;
            $display("FAIL reset_hold: got %h, want %h", act, obs_t'('0));
        end
        rst = 1'b0;
        @(negedge clk_1);
        n_chk++;
        if (act !== idl()) begin
            n_fail++;
            $display("FAIL reset_idle: got %h, want %h", act, idl());
        end
    endtask

    task automatic test_xfer();
        step_t s;
        obs_t  m;
        int    i;
        load(8'h80, 8'h00, 8'h00, 8'hFF, 8'h00);
        sq.push_back(stp(1, 8'hAA, 0, 0, idl()));
        sq.push_back(stp(0, 8'h00, 0, 0,
            ob(0, 5'b01001, 8'h80, 8'h80, 0, 0, 0, 0, 1, 0)));
        sq.push_back(stp(0, 8'h00, 0, 0, idl()));
        i = 0;
        while (sq.size() > 0) begin
            @(negedge clk_1);
            s = sq.pop_front();
            m = msk(s.e);
            n_chk++;
            if ((act & m) !== (s.e & m)) begin
                n_fail++;
                $display("FAIL xfer step %0d: got %h, want %h", i, act & m, s.e & m);
            end
            op_valid = s.v; opcode = s.op; mem_ack = s.ack; mem_rdata = s.rd;
            i++;
        end
    endtask

    task automatic test_incdec();
        step_t s;
        obs_t  m;
        int    i;
        load(8'h80, 8'h01, 8'h00, 8'hFF, 8'h00);
        sq.push_back(stp(1, 8'hCA, 0, 0, idl()));
        sq.push_back(stp(0, 8'h00, 0, 0, ob(0, 5'b01001, 8'h00, 8'h02, 0, 0, 0, 0, 1, 0)));
        sq.push_back(stp(1, 8'hCA, 0, 0, idl()));
        sq.push_back(stp(0, 8'h00, 0, 0, ob(0, 5'b01001, 8'hFF, 8'h80, 0, 0, 0, 0, 1, 0)));
        sq.push_back(stp(1, 8'hE8, 0, 0, idl()));
        sq.push_back(stp(0, 8'h00, 0, 0, ob(0, 5'b01001, 8'h00, 8'h02, 0, 0, 0, 0, 1, 0)));
        sq.push_back(stp(1, 8'h9A, 0, 0, idl()));
        sq.push_back(stp(0, 8'h00, 0, 0, ob(0, 5'b00010, 8'h00, 8'h00, 0, 0, 0, 0, 1, 0)));
        sq.push_back(stp(1, 8'hC8, 0, 0, idl()));
        sq.push_back(stp(0, 8'h00, 0, 0, ob(0, 5'b00101, 8'h01, 8'h00, 0, 0, 0, 0, 1, 0)));
        sq.push_back(stp(1, 8'h88, 0, 0, idl()));
        sq.push_back(stp(0, 8'h00, 0, 0, ob(0, 5'b00101, 8'h00, 8'h02, 0, 0, 0, 0, 1, 0)));
        sq.push_back(stp(1, 8'hBA, 0, 0, idl()));
        sq.push_back(stp(0, 8'h00, 0, 0, ob(0, 5'b01001, 8'h00, 8'h02, 0, 0, 0, 0, 1, 0)));
        sq.push_back(stp(0, 8'h00, 0, 0, idl()));
        i = 0;
        while (sq.size() > 0) begin
            @(negedge clk_1);
            s = sq.pop_front();
            m = msk(s.e);
            n_chk++;
            if ((act & m) !== (s.e & m)) begin
                n_fail++;
                $display("FAIL incdec step %0d: got %h, want %h", i, act & m, s.e & m);
            end
            op_valid = s.v; opcode = s.op; mem_ack = s.ack; mem_rdata = s.rd;
            i++;
        end
    endtask

    task automatic test_back_to_back();
        step_t s;
        obs_t  m;
        int    i;
        load(8'h11, 8'h7F, 8'h00, 8'hFF, 8'h00);
        sq.push_back(stp(1, 8'h8A, 0, 0, idl()));
        sq.push_back(stp(1, 8'h98, 0, 0, ob(0, 5'b10001, 8'h7F, 8'h00, 0, 0, 0, 0, 1, 0)));
        sq.push_back(stp(1, 8'h98, 0, 0, idl()));
        sq.push_back(stp(0, 8'h00, 0, 0, ob(0, 5'b10001, 8'h00, 8'h02, 0, 0, 0, 0, 1, 0)));
        sq.push_back(stp(0, 8'h00, 0, 0, idl()));
        i = 0;
        while (sq.size() > 0) begin
            @(negedge clk_1);
            s = sq.pop_front();
            m = msk(s.e);
            n_chk++;
            if ((act & m) !== (s.e & m)) begin
                n_fail++;
                $display("FAIL b2b step %0d: got %h, want %h", i, act & m, s.e & m);
            end
            op_valid = s.v; opcode = s.op; mem_ack = s.ack; mem_rdata = s.rd;
            i++;
        end
    endtask

    task automatic test_push();
        step_t s;
        obs_t  m;
        obs_t  pu;
        int    i;
        load(8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
        pu = ob(0, 5'b0, 8'h00, 8'h00, 1, 1, 16'h0100, 8'h30, 0, 0);
        sq.push_back(stp(1, 8'h08, 0, 0, idl()));
        sq.push_back(stp(0, 8'h00, 0, 0, pu));
        sq.push_back(stp(0, 8'h00, 0, 0, pu));
        sq.push_back(stp(0, 8'h00, 0, 0, pu));
        sq.push_back(stp(0, 8'h00, 1, 0, pu));
        sq.push_back(stp(0, 8'h00, 1, 0, ob(0, 5'b00010, 8'hFF, 8'h00, 0, 0, 0, 0, 1, 0)));
        sq.push_back(stp(0, 8'h00, 0, 0, idl()));
        i = 0;
        while (sq.size() > 0) begin
            @(negedge clk_1);
            s = sq.pop_front();
            m = msk(s.e);
            n_chk++;
            if ((act & m) !== (s.e & m)) begin
                n_fail++;
                $display("FAIL php step %0d: got %h, want %h", i, act & m, s.e & m);
            end
            op_valid = s.v; opcode = s.op; mem_ack = s.ack; mem_rdata = s.rd;
            i++;
        end
        load(8'h5A, 8'h00, 8'h00, 8'hFF, 8'h00);
        sq.push_back(stp(1, 8'h48, 0, 0, idl()));
        sq.push_back(stp(0, 8'h00, 1, 0, ob(0, 5'b0, 8'h00, 8'h00, 1, 1, 16'h01FF, 8'h5A, 0, 0)));
        sq.push_back(stp(0, 8'h00, 0, 0, ob(0, 5'b00010, 8'hFE, 8'h00, 0, 0, 0, 0, 1, 0)));
        sq.push_back(stp(0, 8'h00, 0, 0, idl()));
        i = 0;
        while (sq.size() > 0) begin
            @(negedge clk_1);
            s = sq.pop_front();
            m = msk(s.e);
            n_chk++;
            if ((act & m) !== (s.e & m)) begin
                n_fail++;
                $display("FAIL pha step %0d: got %h, want %h", i, act & m, s.e & m);
            end
            op_valid = s.v; opcode = s.op; mem_ack = s.ack; mem_rdata = s.rd;
            i++;
        end
    endtask

    task automatic test_pull();
        step_t s;
        obs_t  m;
        int    i;
        load(8'h33, 8'h00, 8'h00, 8'hFF, 8'h00);
        sq.push_back(stp(1, 8'h68, 0, 0, idl()));
        sq.push_back(stp(0, 8'h00, 0, 0, ob(0, 5'b00010, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0)));
        sq.push_back(stp(0, 8'h00, 1, 8'h00, ob(0, 5'b0, 8'h00, 8'h00, 1, 0, 16'h0100, 8'h00, 0, 0)));
        sq.push_back(stp(0, 8'h00, 0, 0, ob(0, 5'b10001, 8'h00, 8'h02, 0, 0, 0, 0, 1, 0)));
        sq.push_back(stp(0, 8'h00, 0, 0, idl()));
        i = 0;
        while (sq.size() > 0) begin
            @(negedge clk_1);
            s = sq.pop_front();
            m = msk(s.e);
            n_chk++;
            if ((act & m) !== (s.e & m)) begin
                n_fail++;
                $display("FAIL pla step %0d: got %h, want %h", i, act & m, s.e & m);
            end
            op_valid = s.v; opcode = s.op; mem_ack = s.ack; mem_rdata = s.rd;
            i++;
        end
        load(8'h33, 8'h00, 8'h00, 8'h10, 8'h00);
        sq.push_back(stp(1, 8'h28, 0, 0, idl()));
        sq.push_back(stp(0, 8'h00, 0, 0, ob(0, 5'b00010, 8'h11, 8'h00, 0, 0, 0, 0, 0, 0)));
        sq.push_back(stp(0, 8'h00, 0, 8'hFF, ob(0, 5'b0, 8'h00, 8'h00, 1, 0, 16'h0111, 8'h00, 0, 0)));
        sq.push_back(stp(0, 8'h00, 1, 8'hFF, ob(0, 5'b0, 8'h00, 8'h00, 1, 0, 16'h0111, 8'h00, 0, 0)));
        sq.push_back(stp(0, 8'h00, 0, 0, ob(0, 5'b00001, 8'h00, 8'hCF, 0, 0, 0, 0, 1, 0)));
        sq.push_back(stp(0, 8'h00, 0, 0, idl()));
        i = 0;
        while (sq.size() > 0) begin
            @(negedge clk_1);
            s = sq.pop_front();
            m = msk(s.e);
            n_chk++;
            if ((act & m) !== (s.e & m)) begin
                n_fail++;
                $display("FAIL plp step %0d: got %h, want %h", i, act & m, s.e & m);
            end
            op_valid = s.v; opcode = s.op; mem_ack = s.ack; mem_rdata = s.rd;
            i++;
        end
    endtask

    task automatic test_illegal();
        step_t s;
        obs_t  m;
        int    i;
        sq.push_back(stp(1, 8'hEA, 0, 0, idl()));
        sq.push_back(stp(0, 8'h00, 0, 0, ob(0, 5'b0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 1)));
        sq.push_back(stp(0, 8'h00, 0, 0, idl()));
        i = 0;
        while (sq.size() > 0) begin
            @(negedge clk_1);
            s = sq.pop_front();
            m = msk(s.e);
            n_chk++;
            if ((act & m) !== (s.e & m)) begin
                n_fail++;
                $display("FAIL illegal step %0d: got %h, want %h", i, act & m, s.e & m);
            end
            op_valid = s.v; opcode = s.op; mem_ack = s.ack; mem_rdata = s.rd;
            i++;
        end
    endtask

    task automatic test_reset_mid();
        step_t s;
        obs_t  m;
        int    i;
        load(8'h00, 8'h00, 8'h00, 8'h20, 8'h00);
        sq.push_back(stp(1, 8'h68, 0, 0, idl()));
        sq.push_back(stp(0, 8'h00, 0, 0, ob(0, 5'b00010, 8'h21, 8'h00, 0, 0, 0, 0, 0, 0)));
        sq.push_back(stp(0, 8'h00, 0, 0, ob(0, 5'b0, 8'h00, 8'h00, 1, 0, 16'h0121, 8'h00, 0, 0)));
        i = 0;
        while (sq.size() > 0) begin
            @(negedge clk_1);
            s = sq.pop_front();
            m = msk(s.e);
            n_chk++;
            if ((act & m) !== (s.e & m)) begin
                n_fail++;
                $display("FAIL rstmid step %0d: got %h, want %h", i, act & m, s.e & m);
            end
            op_valid = s.v; opcode = s.op; mem_ack = s.ack; mem_rdata = s.rd;
            i++;
        end
        #2 rst = 1'b1;
        #1;
        n_chk++;
        if (act !== obs_t'('0)) begin
            n_fail++;
            $display("FAIL rstmid_async: got %h, want %h", act, obs_t'('0));
        end
        @(negedge clk_1);
        n_chk++;
        if (act !== obs_t'('0)) begin
            n_fail++;
            $display("FAIL rstmid_held: got %h, want %h", act, obs_t'('0));
        end
        rst = 1'b0;
        load(8'hC3, 8'h00, 8'h00, 8'h21, 8'h00);
        sq.push_back(stp(1, 8'hA8, 0, 0, idl()));
        sq.push_back(stp(0, 8'h00, 0, 0, ob(0, 5'b00101, 8'hC3, 8'h80, 0, 0, 0, 0, 1, 0)));
        sq.push_back(stp(0, 8'h00, 0, 0, idl()));
        i = 0;
        while (sq.size() > 0) begin
            @(negedge clk_1);
            s = sq.pop_front();
            m = msk(s.e);
            n_chk++;
            if ((act & m) !== (s.e & m)) begin
                n_fail++;
                $display("FAIL tay step %0d: got %h, want %h", i, act & m, s.e & m);
            end
            op_valid = s.v; opcode = s.op; mem_ack = s.ack; mem_rdata = s.rd;
            i++;
        end
    endtask

    initial begin
        test_reset();
        test_xfer();
        test_incdec();
        test_back_to_back();
        test_push();
        test_pull();
        test_illegal();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/reg_transfer_ctrl.md
Name: reg_transfer_ctrl

Overview:
- Sequencer for the CPU register file (A, X, Y, SP, P).
- Accepts one decoded transfer/stack opcode at a time. Drives the file's write strobes (accumulator_con, x_con, y_con, stack_pointer_con, status_con) and its data_in / data_status buses.
- Runs the stack-memory handshake for push/pull ops.
- Sits between the instruction decoder and the register file; the register file captures on the rising clk_1 edge.

Parameters:
- STACK_PAGE, 8'h01, high address byte of the stack.
- PUSH_BMASK, 8'h30, bits forced to 1 in the byte pushed by PHP.

Ports:
- clk_1  input  1  sole clock, rising edge
- rst  input  1  asynchronous, active-high reset
- op_valid  input  1  opcode offered
- op_ready  output  1  controller idle, can accept an opcode
- opcode  input  8  6502 opcode
- acc_q, x_q, y_q, sp_q, status_q  input  8 each  current register file outputs
- accumulator_con, x_con, y_con, stack_pointer_con, status_con  output  1 each  register file write strobes
- data_in  output  8  register file data bus
- data_status  output  8  register file status bus
- mem_req  output  1  stack memory request
- mem_we  output  1  1 = write, 0 = read
- mem_addr  output  16  {STACK_PAGE, sp_q}
- mem_wdata  output  8  push data
- mem_ack  input  1  memory completes the request this cycle
- mem_rdata  input  8  read data, valid with mem_ack
- done  output  1  one-cycle pulse when an op completes
- illegal  output  1  one-cycle pulse when an unsupported opcode is accepted

Behaviour:
- State register and latches use async reset. Outputs are Moore-decoded from state plus latched opcode/data.
- States: IDLE, XFER, PUSH, SP_DEC, SP_INC, PULL, WB, BAD.
- Reset values: state IDLE; all strobes, mem_req, mem_we, done, illegal = 0; data_in, data_status, mem_addr, mem_wdata = 0; op_ready = 0 while rst is high, 1 in IDLE afterwards.
- Handshake: opcode is accepted on the edge where op_valid && op_ready. It is latched, then:
  - transfer ops -> XFER
  - PHA/PHP -> PUSH
  - PLA/PLP -> SP_INC
  - anything else -> BAD
- op_ready = 0 in every state except IDLE.
- Supported transfer ops and results:
  - AA TAX: X = A
  - A8 TAY: Y = A
  - 8A TXA: A = X
  - 98 TYA: A = Y
  - BA TSX: X = SP
  - 9A TXS: SP = X
  - E8 INX: X = X+1
  - CA DEX: X = X-1
  - C8 INY: Y = Y+1
  - 88 DEY: Y = Y-1
  - 8-bit wrap: FF+1 = 00, 00-1 = FF.
- XFER (1 cycle):
  - Exactly one target strobe is high; data_in = result.
  - Except for TXS, status_con = 1 and data_status = status_q with bit7 = result[7] and bit1 = (result == 0).
  - TXS leaves flags unchanged, status_con = 0.
  - done = 1; next state IDLE.
- PUSH:
  - mem_req = 1, mem_we = 1, mem_addr = {STACK_PAGE, sp_q}.
  - mem_wdata = acc_q for PHA, status_q | PUSH_BMASK for PHP.
  - Held stable until mem_ack, then SP_DEC.
- SP_DEC (1 cycle): stack_pointer_con = 1, data_in = sp_q-1, done = 1, then IDLE.
- SP_INC (1 cycle): stack_pointer_con = 1, data_in = sp_q+1, then PULL. PULL therefore sees the updated sp_q.
- PULL:
  - mem_req = 1, mem_we = 0, mem_addr = {STACK_PAGE, sp_q}.
  - On mem_ack, latch mem_rdata, then WB.
- WB (1 cycle), done = 1, then IDLE:
  - PLA: accumulator_con = 1, data_in = latched data; status_con = 1 with N/Z from the data.
  - PLP: status_con = 1, data_status = {d[7:6], status_q[5:4], d[3:0]}.
- BAD (1 cycle): illegal = 1, no strobes, no memory request, then IDLE.
- Strobe rules:
  - At most one of accumulator_con, x_con, y_con, stack_pointer_con is high in any cycle.
  - status_con may accompany any of them.
- Latency from accept edge to done:
  - transfers: 1 cycle
  - push: 2 cycles + memory wait
  - pull: 3 cycles + memory wait
- mem_ack while mem_req = 0 is ignored. mem_ack in the same cycle mem_req first rises is valid (zero-wait memory).
- SP wrap: push at SP = 00 writes 0x0100 and SP becomes FF; pull at SP = FF reads 0x0100 and SP becomes 00.
- rst mid-operation: immediate return to IDLE, mem_req drops asynchronously, any pending SP update is abandoned, and no done is issued.
- op_valid while busy: held off (op_ready = 0), not dropped.

Test Plan:
- Reset, then offer AA with A = 80 -> next cycle x_con = 1, data_in = 80, status_con = 1, data_status bit7 = 1, bit1 = 0, done = 1; op_ready back to 1 the cycle after.
- DEX with X = 01, then INX with X = FF -> data_in = 00 and Z set both times; TXS with X = 00 -> stack_pointer_con = 1, status_con = 0.
- PHP with P = 00, SP = 00, mem_ack delayed 3 cycles -> mem_addr = 0100, mem_wdata = 30 held 4 cycles; then SP written FF, done = 1.
- PLA with SP = FF, zero-wait mem returning 00 -> SP write 00, read address 0100, then A = 00 with Z = 1; done 3 cycles after accept.
- PLP with rdata = FF and P = 00 -> data_status = CF; opcode EA -> illegal pulse, no strobes, no done.
- Assert rst during the PULL wait -> mem_req and all strobes drop immediately, no done; a new TAY after reset release completes normally.
